// File: rtl/inner_fn_issuer.sv
// Credit-gated issuer for a fixed-latency inner-function pipeline; results return in order into a local FIFO.
// Issue is registered (1 cycle); the host stalls on in_ready when in-flight plus buffered results fill the FIFO.
module inner_fn_issuer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int PIPE_LATENCY = 29
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        pipe_start,
  output logic [31:0] pipe_dataa,
  input  logic        pipe_done,
  input  logic [31:0] pipe_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  inflight,
  output logic        busy,
  output logic        err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  generate
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 32 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PIPE_LATENCY < 1)
    begin : g_bad_param
      $fatal(1, "inner_fn_issuer: unsupported FIFO_DEPTH or PIPE_LATENCY");
    end
  endgenerate

  logic          pipe_start_q, pipe_start_d;
  logic [31:0]   pipe_dataa_q, pipe_dataa_d;
  logic [5:0]    inflight_q, inflight_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic       issue;
  logic       push;
  logic       pop;
  logic       spurious;
  logic [6:0] credit_used;

  // Credit uses registered count only, so a pop frees its slot one cycle later.
  always_comb begin
    credit_used = {1'b0, inflight_q} + 7'(count_q);
    in_ready    = clk_en & ~err_q & (credit_used < 7'(FIFO_DEPTH));
    issue       = in_valid & in_ready;
    push        = clk_en & pipe_done & (inflight_q != '0);
    spurious    = clk_en & pipe_done & (inflight_q == '0);
    out_valid   = (count_q != '0);
    pop         = out_valid & out_ready & clk_en;
  end

  always_comb begin
    pipe_start_d = pipe_start_q;
    pipe_dataa_d = pipe_dataa_q;
    inflight_d   = inflight_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_d        = err_q | spurious;

    if (clk_en) begin
      pipe_start_d = issue;
      if (issue) begin
        pipe_dataa_d = in_data;
      end
    end

    if (issue && !push) begin
      inflight_d = inflight_q + 6'd1;
    end else if (push && !issue) begin
      inflight_d = inflight_q - 6'd1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      pipe_start_q <= 1'b0;
      pipe_dataa_q <= '0;
      inflight_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      pipe_start_q <= pipe_start_d;
      pipe_dataa_q <= pipe_dataa_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // Storage needs no reset: out_valid masks stale entries.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pipe_result;
    end
  end

  // The held start is masked while frozen; the pipeline sees it once clk_en returns.
  assign pipe_start = pipe_start_q & clk_en;
  assign pipe_dataa = pipe_dataa_q;
  assign out_data   = mem_q[rd_ptr_q];
  assign inflight   = inflight_q;
  assign busy       = (inflight_q != '0) | out_valid;
  assign err        = err_q;

endmodule

// File: tb/tb_inner_fn_issuer.sv
// Directed bench for inner_fn_issuer with a frozen-on-clk_en pipeline model and an in-order scoreboard.
module tb_inner_fn_issuer;

  localparam int LAT = 29;

  logic        clock;
  logic        aclr;
  logic        clk_en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        pipe_start;
  logic [31:0] pipe_dataa;
  logic        pipe_done;
  logic [31:0] pipe_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  inflight;
  logic        busy;
  logic        err;
  logic        spur;

  int vectors     = 0;
  int miscompares = 0;
  int pops        = 0;
  int lat, c, iss, run, p0;
  logic [31:0] exp_q [$];

  inner_fn_issuer #(.FIFO_DEPTH(8), .PIPE_LATENCY(LAT)) dut (
    .clock(clock), .aclr(aclr), .clk_en(clk_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pipe_start(pipe_start), .pipe_dataa(pipe_dataa),
    .pipe_done(pipe_done), .pipe_result(pipe_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .inflight(inflight), .busy(busy), .err(err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stand-in inner function: adding 1 to the exponent doubles a normal float.
  function automatic logic [31:0] fn(input logic [31:0] x);
    return x + 32'h0080_0000;
  endfunction

  logic [LAT-1:0] pv = '0;
  logic [31:0]    pd [LAT];

  always @(posedge clock) begin
    if (clk_en) begin
      pv    <= {pv[LAT-2:0], pipe_start};
      pd[0] <= fn(pipe_dataa);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end

  assign pipe_done   = pv[LAT-1] | spur;
  assign pipe_result = spur ? 32'hDEAD_BEEF : pd[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (!aclr && clk_en) begin
      if (in_valid && in_ready) exp_q.push_back(fn(in_data));
      if (out_valid && out_ready) begin
        logic nonempty;
        nonempty = (exp_q.size() != 0);
        chk("sb_has_entry", nonempty, 1'b1);
        if (nonempty) chk("sb_order", out_data, exp_q.pop_front());
        pops++;
      end
    end
  end

  task automatic offer(input int n, input logic [31:0] base, input int max_cyc,
                       output int issued, output int first_run);
    bit low_seen;
    issued    = 0;
    first_run = 0;
    low_seen  = 0;
    @(posedge clock); #1;
    in_valid = 1'b1;
    in_data  = base;
    for (int k = 0; k < max_cyc && issued < n; k++) begin
      @(negedge clock);
      if (in_ready) begin
        issued++;
        if (!low_seen) first_run++;
      end else begin
        low_seen = 1;
      end
      @(posedge clock); #1;
      in_data = base + 32'(issued) * 32'h0001_0000;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    @(negedge clock);
    while ((busy || exp_q.size() != 0) && k < max_cyc) begin
      @(negedge clock);
      k++;
    end
    chk("idle_in_time", k < max_cyc, 1'b1);
    @(posedge clock); #1;
  endtask

  initial begin
    aclr = 1'b1; clk_en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; spur = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_pipe_start", pipe_start, 1'b0);
    chk("rst_pipe_dataa", pipe_dataa, 32'h0);
    chk("rst_inflight", inflight, 6'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_in_ready_clk_en0", in_ready, 1'b0);
    @(posedge clock); #1;
    aclr = 1'b0; clk_en = 1'b1;
    @(negedge clock);
    chk("in_ready_after_rst", in_ready, 1'b1);

    // Single operand 128.0
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = 32'h4300_0000;
    @(negedge clock);
    chk("single_accept", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("single_start", pipe_start, 1'b1);
    chk("single_dataa", pipe_dataa, 32'h4300_0000);
    chk("single_inflight", inflight, 6'd1);
    chk("single_busy", busy, 1'b1);
    @(negedge clock);
    chk("single_start_pulse", pipe_start, 1'b0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    chk("single_latency", lat, 30);
    chk("single_result", out_data, 32'h4380_0000);
    chk("single_inflight_back", inflight, 6'd0);
    @(posedge clock); #1; out_ready = 1'b1;
    @(posedge clock); #1; out_ready = 1'b0;
    @(negedge clock);
    chk("single_popped", out_valid, 1'b0);
    chk("single_idle", busy, 1'b0);

    // Burst of 20 with host always ready
    out_ready = 1'b1;
    p0 = pops;
    offer(20, 32'h3F80_0000, 500, iss, run);
    chk("burst_issued", iss, 20);
    chk("burst_first_run", run, 8);
    wait_idle(400);
    chk("burst_pops", pops - p0, 20);
    chk("burst_err", err, 1'b0);

    // Host stalled: exactly the FIFO depth may issue
    out_ready = 1'b0;
    p0 = pops;
    offer(10, 32'h4000_0000, 60, iss, run);
    chk("stall_issued", iss, 8);
    @(negedge clock);
    chk("stall_inflight", inflight, 6'd0);
    chk("stall_out_valid", out_valid, 1'b1);
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_busy", busy, 1'b1);
    @(posedge clock); #1;
    out_ready = 1'b1;
    offer(2, 32'h4008_0000, 100, iss, run);
    chk("stall_rest_issued", iss, 2);
    wait_idle(200);
    chk("stall_pops", pops - p0, 10);

    // clk_en freeze with three in flight
    p0 = pops;
    offer(3, 32'h4100_0000, 20, iss, run);
    clk_en = 1'b0; in_valid = 1'b1; in_data = 32'h4400_0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("freeze_start", pipe_start, 1'b0);
      chk("freeze_in_ready", in_ready, 1'b0);
      chk("freeze_inflight", inflight, 6'd3);
      @(posedge clock); #1;
      spur = (k == 0);
    end
    spur = 1'b0; clk_en = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    chk("freeze_resume_start", pipe_start, 1'b1);
    chk("freeze_done_ignored", err, 1'b0);
    wait_idle(200);
    chk("freeze_pops", pops - p0, 3);

    // Spurious done with nothing in flight
    out_ready = 1'b0;
    offer(1, 32'h3F00_0000, 10, iss, run);
    c = 0;
    while (!(out_valid && inflight == 6'd0) && c < 100) begin
      @(negedge clock);
      c++;
    end
    chk("spur_setup_in_time", c < 100, 1'b1);
    @(posedge clock); #1; spur = 1'b1;
    @(negedge clock);
    chk("spur_err_before", err, 1'b0);
    @(posedge clock); #1; spur = 1'b0;
    @(negedge clock);
    chk("spur_err", err, 1'b1);
    chk("spur_in_ready", in_ready, 1'b0);
    chk("spur_fifo_valid", out_valid, 1'b1);
    chk("spur_fifo_data", out_data, 32'h3F80_0000);
    chk("spur_inflight", inflight, 6'd0);
    @(posedge clock); #1; out_ready = 1'b1;
    @(posedge clock); #1; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("spur_err_sticky", err, 1'b1);
    chk("spur_fifo_drained", out_valid, 1'b0);
    @(posedge clock); #1; aclr = 1'b1; exp_q.delete();
    #2;
    chk("err_cleared_by_aclr", err, 1'b0);
    @(posedge clock); #1; aclr = 1'b0;

    // Reset with three in flight
    out_ready = 1'b1;
    offer(3, 32'h4200_0000, 20, iss, run);
    chk("rst_mid_issued", iss, 3);
    @(negedge clock);
    chk("rst_mid_inflight_before", inflight, 6'd3);
    #2; aclr = 1'b1; exp_q.delete();
    #1;
    chk("rst_mid_pipe_start", pipe_start, 1'b0);
    chk("rst_mid_pipe_dataa", pipe_dataa, 32'h0);
    chk("rst_mid_inflight", inflight, 6'd0);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(posedge clock); #1; aclr = 1'b0;
    c = 0;
    while (!err && c < 60) begin
      @(negedge clock);
      c++;
    end
    chk("late_done_err", err, 1'b1);
    chk("late_done_discarded", out_valid, 1'b0);
    chk("late_done_inflight", inflight, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inner_fn_issuer.md
INNER_FN_ISSUER -- requirements
Module: inner_fn_issuer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning result buffer entries (power of 2, 2..32).
REQ-002 SHALL have parameter PIPE_LATENCY, default 29, meaning fixed start-to-done latency of the attached inner-function pipeline (4 mult + 8 add + 17 cordic).
REQ-003 SHALL have ports, in order (name  direction  width  meaning):
- clock  in  1  single clock, rising edge.
- aclr  in  1  asynchronous active-high reset.
- clk_en  in  1  global enable, shared with the pipeline.
- in_valid  in  1  host operand valid.
- in_ready  out  1  block accepts operand.
- in_data  in  32  IEEE-754 single operand x.
- pipe_start  out  1  one-cycle issue strobe to pipeline start.
- pipe_dataa  out  32  operand to pipeline dataa.
- pipe_done  in  1  pipeline done strobe.
- pipe_result  in  32  pipeline result, valid with pipe_done.
- out_valid  out  1  buffered result available.
- out_ready  in  1  host consumes result.
- out_data  out  32  oldest buffered result.
- inflight  out  6  operands issued but not yet returned.
- busy  out  1  inflight != 0 or FIFO non-empty.
- err  out  1  sticky protocol error.

Function
REQ-004 SHALL treat the pipeline as a responder with no backpressure; every issued operand SHALL return exactly PIPE_LATENCY cycles later and SHALL be captured in order.
REQ-005 SHALL use credit-based flow control: in_ready = clk_en & ~err & (inflight + fifo_count < FIFO_DEPTH).
REQ-006 SHALL, on in_valid & in_ready at a rising edge, register pipe_dataa <= in_data and pipe_start <= 1 for exactly one cycle; else pipe_start <= 0 and pipe_dataa holds.
- Issue rate: one operand per cycle max.
REQ-007 SHALL increment inflight on issue; decrement on pipe_done; both same cycle: unchanged.
REQ-008 SHALL write pipe_result into the FIFO tail on pipe_done (when inflight != 0).
REQ-009 SHALL present FIFO head on out_data with out_valid = (fifo_count != 0); pop on out_valid & out_ready & clk_en.
REQ-010 SHALL support simultaneous push and pop in one cycle; fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
- Push into a FIFO that is empty that cycle: visible on out_data the next cycle (no fall-through).
REQ-011 SHALL never overflow: credit rule guarantees free slot for every returning result; a pop in the current cycle SHALL NOT be counted as credit until the following cycle.
REQ-012 SHALL set err (sticky) on pipe_done while inflight == 0; that result SHALL be discarded; in_ready forced 0 while err.
REQ-013 SHALL, while clk_en = 0, hold all state, drive pipe_start = 0, in_ready = 0, and perform no pop; pipe_done SHALL be ignored (pipeline is frozen by the same clk_en).
REQ-014 SHALL drive busy = (inflight != 0) | (fifo_count != 0) combinationally.

Reset
REQ-015 SHALL, on aclr high (asynchronous, any cycle including mid-burst), clear pipe_start=0, pipe_dataa=0, inflight=0, FIFO pointers/count=0, out_valid=0, err=0; in-flight results arriving after reset release SHALL raise err per REQ-012.
REQ-016 SHALL resume normal operation on the first rising edge after aclr deasserts.

Verification
REQ-017 Single op: in_data=0x43000000 (128.0), behavioural pipeline model -> pipe_start pulse 1 cycle after accept, out_valid rises PIPE_LATENCY+1 cycles after pipe_start, out_data = model result, inflight returns to 0.
REQ-018 Back-to-back burst of 20 operands, out_ready=1 -> in_ready drops after 8 issues, stays low until pops return credit; all 20 results in order, err=0.
REQ-019 out_ready=0 throughout, 10 operands offered -> exactly 8 issued, FIFO reaches 8, no overflow; raising out_ready drains 8 in order, then remaining 2 issue.
REQ-020 Spurious pipe_done with inflight=0 -> err=1 next cycle, in_ready=0, FIFO unchanged; cleared only by aclr.
REQ-021 clk_en=0 for 5 cycles mid-burst (pipeline model frozen) -> no state change, pipe_start=0; results correct after clk_en=1.
REQ-022 aclr pulse with 3 in flight -> all outputs reset immediately; late pipe_done sets err.
